// File: rtl/fetch_prefetch_pkg.sv
// Shared types and opcodes for the instruction-fetch front end.
package fetch_prefetch_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef logic [XLEN_DEF-1:0] data_t;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // One prefetch-queue entry as handed to decode.
    typedef struct packed {
        data_t pc;
        data_t instr;
        logic  taken;
    } fetch_entry_t;

endpackage

// File: rtl/bpred_static.sv
// Static branch predictor: JAL always taken, backward conditional branches taken.
// Ports:
//   pc        address of the instruction being predicted
//   instr     instruction word
//   taken_c   prediction (combinational)
//   target_c  predicted target (combinational, pc when not taken)
module bpred_static
    import fetch_prefetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
)(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    output logic            taken_c,
    output logic [XLEN-1:0] target_c
);

    logic [20:0] imm_j;
    logic [12:0] imm_b;

    // Immediates are sign-extended from their encoded width to XLEN.
    always_comb begin
        imm_j    = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_b    = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        taken_c  = 1'b0;
        target_c = pc;
        if (instr[6:0] == OPC_JAL) begin
            taken_c  = 1'b1;
            target_c = pc + XLEN'($signed(imm_j));
        end else if (instr[6:0] == OPC_BRANCH && instr[31]) begin
            taken_c  = 1'b1;
            target_c = pc + XLEN'($signed(imm_b));
        end
    end

endmodule

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue with flush, push, pop and occupancy count.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           clears pointers and count (wins over push/pop)
//   push/push_data  write one entry at the tail
//   pop             retire the head entry
//   head            entry at the read pointer (undefined while count==0)
//   count           occupancy, 0..DEPTH
module fetch_fifo
    import fetch_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PW     = $clog2(DEPTH),
    localparam int unsigned CW     = PW + 1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: head is only consumed while count is nonzero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: sequential fetch, DEPTH-entry prefetch queue,
// redirect flush with in-flight response discard.
// Build option: define FETCH_BPRED_EN to add static branch prediction on
// responses; otherwise fetch is purely sequential and out_taken is 0.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   redirect_valid, redirect_pc      resolved redirect (highest priority)
//   imem_req_valid/ready/addr        fetch request handshake
//   imem_rsp_valid/data              in-order responses, one per accepted request
//   out_valid/ready                  head-of-queue handshake to decode
//   out_pc, out_pc_p4, out_instr,
//   out_taken                        head entry fields (zero while out_valid=0)
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_p4,
    output logic [XLEN-1:0] out_instr,
    output logic            out_taken
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            taken;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;       // pc of the next response that will be kept
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   count;
    logic            fetch_en;     // holds off requests until the first edge after reset
    logic            accept;
    logic            keep;
    logic            pop;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    entry_t          push_data;
    entry_t          head;

`ifdef FETCH_BPRED_EN
    logic pred_raw;

    bpred_static #(.XLEN(XLEN)) u_bpred (
        .pc       (rsp_pc),
        .instr    (imem_rsp_data),
        .taken_c  (pred_raw),
        .target_c (pred_target)
    );

    assign pred_taken = keep && pred_raw;
`else
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
`endif

    // Queue slots plus in-flight requests never exceed DEPTH, so every response has room.
    assign imem_req_valid  = fetch_en && !redirect_valid &&
                             (({1'b0, count} + {1'b0, outstanding}) < SW'(DEPTH));
    assign imem_req_addr   = fetch_pc;
    assign accept          = imem_req_valid && imem_req_ready;
    assign keep            = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign pop             = out_valid && out_ready && !redirect_valid;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    assign push_data       = '{pc: rsp_pc, instr: imem_rsp_data, taken: pred_taken};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (keep),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Fetch/response pointers and discard bookkeeping; redirect beats prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en    <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                rsp_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
                discard  <= outstanding_nxt;
            end else if (pred_taken) begin
                fetch_pc <= pred_target;
                rsp_pc   <= pred_target;
                discard  <= outstanding_nxt;
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (keep) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                end else if (imem_rsp_valid) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    // Head fields are masked so an empty queue presents all-zero data.
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head.pc            : '0;
    assign out_pc_p4 = out_valid ? head.pc + XLEN'(4) : '0;
    assign out_instr = out_valid ? head.instr         : '0;
    assign out_taken = out_valid && head.taken;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: memory model with configurable
// latency, an architectural fetch-stream model, and directed scenarios.
module tb_fetch_prefetch;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk            = 1'b0;
    logic            rst_n          = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc    = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b1;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [XLEN-1:0] imem_rsp_data  = '0;
    logic            out_valid;
    logic            out_ready      = 1'b1;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_p4;
    logic [XLEN-1:0] out_instr;
    logic            out_taken;

    always #5 clk = ~clk;

    fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pc_p4      (out_pc_p4),
        .out_instr      (out_instr),
        .out_taken      (out_taken)
    );

    int checks   = 0;
    int failures = 0;
    int lat      = 1;
    int cyc      = 0;
    bit jal_armed = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] acc_log[$];
    logic [31:0] dlv_log[$];
    logic [31:0] dlv_p4[$];
    logic        dlv_taken[$];
    logic [31:0] model_pc = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Program image: addi-style filler, plus "jal x0,-16" at 0x20 when armed.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (jal_armed && addr == 32'h20) return 32'hFF1FF06F;
        return {addr[24:0], 7'h13};
    endfunction

    // Expected prediction from the instruction encoding.
    function automatic logic [32:0] model_pred(input logic [31:0] pc, input logic [31:0] ins);
`ifdef FETCH_BPRED_EN
        int imm;
        if (ins[6:0] == 7'b1101111) begin
            imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            return {1'b1, pc + 32'(imm)};
        end
        if (ins[6:0] == 7'b1100011 && ins[31]) begin
            imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            return {1'b1, pc + 32'(imm)};
        end
`endif
        return {1'b0, pc + 32'h4};
    endfunction

    // Memory: accept sampled mid-cycle, response presented lat cycles after acceptance.
    initial forever begin
        logic        a_acc;
        logic [31:0] a_addr;
        @(negedge clk);
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            continue;
        end
        a_acc  = imem_req_valid && imem_req_ready;
        a_addr = imem_req_addr;
        @(posedge clk);
        cyc++;
        if (a_acc) begin
            pend.push_back('{addr: a_addr, due: cyc + lat - 1});
            acc_log.push_back(a_addr);
        end
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Every delivered entry must be the next instruction of the architectural stream.
    initial forever begin
        logic [32:0] pr;
        logic [31:0] ins;
        @(negedge clk);
        if (!rst_n) begin
            model_pc = 32'h0;
        end else begin
            if (redirect_valid) check("req_during_redirect", 32'(imem_req_valid), 32'h0);
            if (out_valid) begin
                check("pc_p4", out_pc_p4, out_pc + 32'h4);
                if (out_ready && !redirect_valid) begin
                    ins = mem_word(model_pc);
                    pr  = model_pred(model_pc, ins);
                    check("stream_pc", out_pc, model_pc);
                    check("stream_instr", out_instr, ins);
                    check("stream_taken", 32'(out_taken), 32'(pr[32]));
                    dlv_log.push_back(out_pc);
                    dlv_p4.push_back(out_pc_p4);
                    dlv_taken.push_back(out_taken);
                    model_pc = pr[31:0];
                end
            end
            if (redirect_valid) model_pc = redirect_pc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        step(3);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_pc_p4", out_pc_p4, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_taken", 32'(out_taken), 32'h0);
        acc_log.delete();
        dlv_log.delete();
        dlv_p4.delete();
        dlv_taken.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_dlv(input int n, input string tag);
        int k = 0;
        while (dlv_log.size() < n && k < 300) begin
            step(1);
            k++;
        end
        if (dlv_log.size() < n) check(tag, 32'(dlv_log.size()), 32'(n));
    endtask

    task automatic wait_acc(input int n, input string tag);
        int k = 0;
        while (acc_log.size() < n && k < 300) begin
            step(1);
            k++;
        end
        if (acc_log.size() < n) check(tag, 32'(acc_log.size()), 32'(n));
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int n0;
        int na;
        #1;
        rst_n = 1'b0;

        // 1: sequential streaming, one entry per cycle
        lat = 1;
        do_reset();
        wait_dlv(1, "t1_timeout");
        n0 = dlv_log.size();
        repeat (8) @(negedge clk);
        check("t1_throughput", 32'(dlv_log.size() - n0), 32'd8);
        step(1);
        check("t1_acc0", acc_log[0], 32'h0);
        check("t1_acc1", acc_log[1], 32'h4);
        check("t1_acc2", acc_log[2], 32'h8);
        check("t1_dlv0", dlv_log[0], 32'h0);
        check("t1_dlv2", dlv_log[2], 32'h8);
        check("t1_p4_0", dlv_p4[0], 32'h4);

        // 2: decode stalled, issue stops at DEPTH, then drains in order
        out_ready = 1'b0;
        do_reset();
        step(10);
        check("t2_issued", 32'(acc_log.size()), 32'(DEPTH));
        @(negedge clk);
        check("t2_req_blocked", 32'(imem_req_valid), 32'h0);
        step(1);
        out_ready = 1'b1;
        wait_dlv(4, "t2_drain_timeout");
        check("t2_dlv0", dlv_log[0], 32'h0);
        check("t2_dlv1", dlv_log[1], 32'h4);
        check("t2_dlv2", dlv_log[2], 32'h8);
        check("t2_dlv3", dlv_log[3], 32'hC);
        wait_acc(5, "t2_resume_timeout");
        check("t2_resume_addr", acc_log[4], 32'h10);

        // 3: memory back-pressure holds the address
        do_reset();
        wait_acc(2, "t3_acc_timeout");
        imem_req_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(imem_req_valid), 32'h1);
            check("t3_hold_addr", imem_req_addr, 32'h8);
        end
        step(1);
        imem_req_ready = 1'b1;
        wait_dlv(6, "t3_dlv_timeout");
        check("t3_acc2", acc_log[2], 32'h8);
        check("t3_dlv2", dlv_log[2], 32'h8);
        check("t3_dlv3", dlv_log[3], 32'hC);

        // 4: redirect with two responses in flight
        lat = 2;
        do_reset();
        wait_acc(6, "t4_acc_timeout");
        n0 = dlv_log.size();
        redirect(32'h100);
        @(negedge clk);
        check("t4_flushed", 32'(out_valid), 32'h0);
        wait_dlv(n0 + 3, "t4_dlv_timeout");
        check("t4_first_after", dlv_log[n0], 32'h100);
        check("t4_second_after", dlv_log[n0 + 1], 32'h104);

        // 5: address wrap at the top of the address space
        lat = 1;
        do_reset();
        wait_dlv(2, "t5_start_timeout");
        na = acc_log.size();
        n0 = dlv_log.size();
        redirect(32'hFFFF_FFFC);
        wait_dlv(n0 + 3, "t5_dlv_timeout");
        check("t5_acc_top", acc_log[na], 32'hFFFF_FFFC);
        check("t5_acc_wrap", acc_log[na + 1], 32'h0);
        check("t5_dlv_top", dlv_log[n0], 32'hFFFF_FFFC);
        check("t5_p4_wrap", dlv_p4[n0], 32'h0);
        check("t5_dlv_wrap", dlv_log[n0 + 1], 32'h0);

`ifdef FETCH_BPRED_EN
        // 6: JAL predicted taken, younger fetches dropped
        jal_armed = 1'b1;
        n0 = dlv_log.size();
        redirect(32'h18);
        wait_dlv(n0 + 6, "t6_dlv_timeout");
        check("t6_dlv0", dlv_log[n0], 32'h18);
        check("t6_dlv2", dlv_log[n0 + 2], 32'h20);
        check("t6_taken_jal", 32'(dlv_taken[n0 + 2]), 32'h1);
        check("t6_taken_seq", 32'(dlv_taken[n0 + 1]), 32'h0);
        check("t6_target", dlv_log[n0 + 3], 32'h10);
        check("t6_after_target", dlv_log[n0 + 4], 32'h14);
`endif

        step(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
